zeroriscy_irq_arbiter: RTL and testbench

Multi-source successor to the single-line zero-riscy interrupt controller. It accepts NUM_IRQ interrupt lines, each configurable as level- or edge-triggered, with a per-line enable mask. It arbitrates by fixed priority and presents one request/ID pair to the core controller using the same request/ack/kill handshake. It sits between the external interrupt lines, the CSR file and the ID-stage controller.

---
 rtl/zeroriscy_irq_arbiter.sv | 145 ++++++++++++++
 tb/tb_zeroriscy_irq_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_irq_arbiter.sv
// ---------------------------------------------------------------------------
// zeroriscy_irq_arbiter
//
// Multi-source interrupt arbiter for the zero-riscy core. Each of NUM_IRQ
// lines is either level- or rising-edge-triggered (IRQ_EDGE). Pending lines
// that are enabled compete by fixed priority (lowest index wins). The winner
// is offered to the ID-stage controller with a request/ack/kill handshake.
// Once a request is issued its ID is frozen until the controller acks or kills.
//
// Ports
//   clk            in   core clock, all state on rising edge
//   rst_n          in   synchronous active-low reset
//   irq_i          in   interrupt lines (already synchronous to clk)
//   irq_en_i       in   per-line enable mask (CSR)
//   m_IE_i         in   global M-mode interrupt enable (CSR)
//   irq_req_ctrl_o out  request to controller
//   irq_id_ctrl_o  out  ID of requested interrupt (zero-extended)
//   ctrl_ack_i     in   controller accepted the request
//   ctrl_kill_i    in   controller abandoned the request
//   irq_ack_o      out  one-cycle pulse: interrupt taken
//   irq_ack_id_o   out  ID of taken interrupt, 0 when irq_ack_o is low
//   irq_pending_o  out  pending register for CSR readback
// ---------------------------------------------------------------------------
module zeroriscy_irq_arbiter #(
  parameter int                 NUM_IRQ  = 32,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               m_IE_i,
  output logic               irq_req_ctrl_o,
  output logic [4:0]         irq_id_ctrl_o,
  input  logic               ctrl_ack_i,
  input  logic               ctrl_kill_i,
  output logic               irq_ack_o,
  output logic [4:0]         irq_ack_id_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] IRQ_PENDING = 2'd1;
  localparam logic [1:0] IRQ_DONE    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [4:0]         id_q, id_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] eligible;
  logic               req_q, ack_q;
  logic [4:0]         ack_id_q;

  // Fixed priority: scanning downwards lets the lowest set index overwrite last.
  function automatic logic [4:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = 5'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign eligible = pend_q & irq_en_i;

  // Next pending value: level lines follow the input, edge lines latch rising
  // edges and clear on ack of their own ID (a new edge in the same cycle wins).
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (IRQ_EDGE[i]) begin
        pend_d[i] = (irq_i[i] & ~irq_prev_q[i]) |
                    (pend_q[i] & ~((state_q == IRQ_PENDING) && ctrl_ack_i &&
                                   (id_q == 5'(i))));
      end else begin
        pend_d[i] = irq_i[i];
      end
    end
  end

  // Handshake FSM next state; id_q only moves when a request is issued.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (m_IE_i && (|eligible)) begin
          state_d = IRQ_PENDING;
          id_d    = lowest_set(eligible);
        end else begin
          state_d = IDLE;
        end
      end
      IRQ_PENDING: begin
        // Ack takes precedence over kill when both arrive together.
        if (ctrl_ack_i) begin
          state_d = IRQ_DONE;
        end else if (ctrl_kill_i) begin
          state_d = IDLE;
        end else begin
          state_d = IRQ_PENDING;
        end
      end
      IRQ_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; outputs are registered from the next-state decode so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 5'd0;
      irq_prev_q <= '0;
      pend_q     <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      ack_id_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      irq_prev_q <= irq_i;
      pend_q     <= pend_d;
      req_q      <= (state_d == IRQ_PENDING);
      ack_q      <= (state_d == IRQ_DONE);
      ack_id_q   <= (state_d == IRQ_DONE) ? id_d : 5'd0;
    end
  end

  assign irq_req_ctrl_o = req_q;
  assign irq_id_ctrl_o  = id_q;
  assign irq_ack_o      = ack_q;
  assign irq_ack_id_o   = ack_id_q;
  assign irq_pending_o  = pend_q;

endmodule

// File: tb/tb_zeroriscy_irq_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for zeroriscy_irq_arbiter: a 32-line and a 4-line instance share
// the same stimulus and are compared every cycle against a transaction-level
// reference model (pending bits, outstanding request, pending ack pulse).
// ---------------------------------------------------------------------------
module tb_zeroriscy_irq_arbiter;

  localparam logic [31:0] EDGE0 = 32'hAAAA_0F80;
  localparam logic [3:0]  EDGE1 = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq;
  logic [31:0] en;
  logic        mie;
  logic        ack;
  logic        kill;

  logic        req0, ackp0;
  logic [4:0]  id0, ackid0;
  logic [31:0] pend0;
  logic        req1, ackp1;
  logic [4:0]  id1, ackid1;
  logic [3:0]  pend1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one slot per instance
  logic [31:0] m_pend [2];
  logic [31:0] m_prev [2];
  logic        m_req  [2];
  logic        m_ackp [2];
  logic [4:0]  m_id   [2];

  always #5 clk = ~clk;

  zeroriscy_irq_arbiter #(.NUM_IRQ(32), .IRQ_EDGE(EDGE0)) dut0 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(en), .m_IE_i(mie),
    .irq_req_ctrl_o(req0), .irq_id_ctrl_o(id0), .ctrl_ack_i(ack),
    .ctrl_kill_i(kill), .irq_ack_o(ackp0), .irq_ack_id_o(ackid0),
    .irq_pending_o(pend0)
  );

  zeroriscy_irq_arbiter #(.NUM_IRQ(4), .IRQ_EDGE(EDGE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .irq_i(irq[3:0]), .irq_en_i(en[3:0]), .m_IE_i(mie),
    .irq_req_ctrl_o(req1), .irq_id_ctrl_o(id1), .ctrl_ack_i(ack),
    .ctrl_kill_i(kill), .irq_ack_o(ackp1), .irq_ack_id_o(ackid1),
    .irq_pending_o(pend1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] line_mask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic logic [31:0] edge_mask(input int k);
    return (k == 0) ? EDGE0 : {28'd0, EDGE1};
  endfunction

  // Advance the model of instance k by one clock edge using current inputs.
  task automatic model_edge(input int k);
    logic [31:0] msk, edg, ir, elig, np;
    int          win;
    msk = line_mask(k);
    edg = edge_mask(k);
    ir  = irq & msk;
    if (!rst_n) begin
      m_pend[k] = 32'd0;
      m_prev[k] = 32'd0;
      m_req[k]  = 1'b0;
      m_ackp[k] = 1'b0;
      m_id[k]   = 5'd0;
    end else begin
      elig = m_pend[k] & en & msk;
      np   = 32'd0;
      for (int i = 0; i < 32; i++) begin
        if (edg[i]) begin
          np[i] = (ir[i] && !m_prev[k][i]) ||
                  (m_pend[k][i] && !(m_req[k] && ack && (int'(m_id[k]) == i)));
        end else begin
          np[i] = ir[i];
        end
      end
      if (m_ackp[k]) begin
        m_ackp[k] = 1'b0;
      end else if (m_req[k]) begin
        if (ack) begin
          m_req[k]  = 1'b0;
          m_ackp[k] = 1'b1;
        end else if (kill) begin
          m_req[k] = 1'b0;
        end
      end else if (mie && (elig != 32'd0)) begin
        win = 0;
        while (!elig[win]) win++;
        m_req[k] = 1'b1;
        m_id[k]  = 5'(win);
      end
      m_pend[k] = np;
      m_prev[k] = ir;
    end
  endtask

  // One clock: update the model at the edge, then compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_val("req0",   32'(req0),   32'(m_req[0]));
    check_val("id0",    32'(id0),    32'(m_id[0]));
    check_val("ack0",   32'(ackp0),  32'(m_ackp[0]));
    check_val("ackid0", 32'(ackid0), m_ackp[0] ? 32'(m_id[0]) : 32'd0);
    check_val("pend0",  pend0,       m_pend[0]);
    check_val("req1",   32'(req1),   32'(m_req[1]));
    check_val("id1",    32'(id1),    32'(m_id[1]));
    check_val("ack1",   32'(ackp1),  32'(m_ackp[1]));
    check_val("ackid1", 32'(ackid1), m_ackp[1] ? 32'(m_id[1]) : 32'd0);
    check_val("pend1",  32'(pend1),  m_pend[1] & 32'h0000_000F);
    check_val("id1_hi", 32'(id1[4:2]), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; irq = 32'd0; en = 32'hFFFF_FFFF; mie = 1'b1;
    ack = 1'b0; kill = 1'b0;
    run(2);
    rst_n = 1'b1;

    // Level line 5: request, ack, re-request while still high
    irq = 32'h0000_0020; run(3);
    ack = 1'b1; run(1); ack = 1'b0; run(4);
    irq = 32'd0; ack = 1'b1; run(1); ack = 1'b0; run(3);

    // Lines 3 and 9 together: 3 first, then 9 after 3 drops
    irq = 32'h0000_0208; run(3);
    ack = 1'b1; run(1); ack = 1'b0; irq = 32'h0000_0200; run(3);
    ack = 1'b1; run(1); ack = 1'b0; irq = 32'd0; run(3);

    // Edge line 7 pulse: kill keeps it pending, ack clears it
    irq = 32'h0000_0080; run(1); irq = 32'd0; run(2);
    kill = 1'b1; run(1); kill = 1'b0; run(2);
    ack = 1'b1; run(1); ack = 1'b0; run(3);

    // ID frozen while outstanding; ack and kill together take the ack path
    irq = 32'h0000_0200; run(2);
    irq = 32'h0000_0204; run(3);
    ack = 1'b1; kill = 1'b1; run(1); ack = 1'b0; kill = 1'b0; irq = 32'd0; run(4);
    ack = 1'b1; run(1); ack = 1'b0; run(3);

    // Gated by m_IE_i and by the line enable
    irq = 32'h0000_0010; mie = 1'b0; run(3);
    mie = 1'b1; en = 32'hFFFF_FFEF; run(3);
    en = 32'hFFFF_FFFF; run(2);
    ack = 1'b1; run(1); ack = 1'b0; irq = 32'd0; run(3);

    // Reset while a request is outstanding
    irq = 32'h0000_0022; run(3);
    rst_n = 1'b0; run(1); rst_n = 1'b1; run(3);
    irq = 32'd0; ack = 1'b1; run(2); ack = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq   = irq ^ ($urandom & $urandom & $urandom);
      en    = ~($urandom & $urandom & $urandom);
      mie   = ($urandom_range(7) != 0);
      ack   = ($urandom_range(2) == 0);
      kill  = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
